// File: rtl/mem_ddr_load_seq.sv
// DDR->SRAM load sequencer: splits a copy into DDR read bursts and tags each returning beat.
// Optional MEM_LOAD_4K_SPLIT_EN keeps every burst inside one 4 KB DDR page.
`timescale 1ns/1ps
module mem_ddr_load_seq #(
    parameter int BEAT_BYTES = 16,
    parameter int MAX_BURST  = 16,
    parameter int SRAM_AW    = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        ddr_src_addr,
    input  logic [SRAM_AW-1:0] sram_dst_addr,
    input  logic [19:0]        len_bytes,
    output logic               busy,
    output logic               done,
    output logic               ddr_rd_req,
    output logic [31:0]        ddr_rd_addr,
    output logic [4:0]         ddr_rd_len,
    input  logic               ddr_rd_gnt,
    input  logic               ddr_data_valid,
    output logic [SRAM_AW-1:0] base_addr,
    output logic               last,
    output logic [3:0]         num_of_last_valid
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] rd_ptr;
    logic [16:0] remaining;
    logic [4:0]  burst_cnt;
    logic [31:0] src_aligned;
    logic [16:0] start_beats;
    logic [31:0] cand_ptr;
    logic [16:0] cand_rem;
    logic [16:0] burst_lim;
    logic [4:0]  cand_len;
    logic        beat_in_burst;
    logic        burst_end;
    logic        unused_src_bits;
`ifdef MEM_LOAD_4K_SPLIT_EN
    logic [8:0]  to_4k;
`endif

    assign src_aligned     = {ddr_src_addr[31:4], 4'h0};
    assign unused_src_bits = ^ddr_src_addr[3:0];
    assign start_beats     = 17'((21'(len_bytes) + 21'(BEAT_BYTES - 1)) / 21'(BEAT_BYTES));

    assign beat_in_burst = ddr_data_valid && (state == DATA);
    assign burst_end     = beat_in_burst && (burst_cnt == 5'd1);
    assign last          = burst_end && (remaining == 17'd0);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    // The next burst is sized from the start inputs in IDLE, otherwise from the running pointer.
    always_comb begin
        cand_ptr  = (state == IDLE) ? src_aligned : rd_ptr;
        cand_rem  = (state == IDLE) ? start_beats : remaining;
        burst_lim = cand_rem;
        if (burst_lim > 17'(MAX_BURST)) begin
            burst_lim = 17'(MAX_BURST);
        end
`ifdef MEM_LOAD_4K_SPLIT_EN
        to_4k = 9'd256 - {1'b0, cand_ptr[11:4]};
        if ({8'd0, to_4k} < burst_lim) begin
            burst_lim = {8'd0, to_4k};
        end
`endif
        cand_len = burst_lim[4:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_bytes == 20'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (ddr_rd_gnt) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (burst_end) begin
                    state_next = (remaining != 17'd0) ? REQ : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr            <= 32'd0;
            remaining         <= 17'd0;
            burst_cnt         <= 5'd0;
            base_addr         <= '0;
            num_of_last_valid <= 4'd0;
            ddr_rd_req        <= 1'b0;
            ddr_rd_addr       <= 32'd0;
            ddr_rd_len        <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_of_last_valid <= len_bytes[3:0];
                        base_addr         <= sram_dst_addr;
                        rd_ptr            <= src_aligned;
                        remaining         <= start_beats;
                        if (len_bytes != 20'd0) begin
                            ddr_rd_req  <= 1'b1;
                            ddr_rd_addr <= cand_ptr;
                            ddr_rd_len  <= cand_len;
                        end
                    end
                end
                REQ: begin
                    if (ddr_rd_gnt) begin
                        ddr_rd_req <= 1'b0;
                        burst_cnt  <= ddr_rd_len;
                        rd_ptr     <= rd_ptr + (32'(ddr_rd_len) * 32'(BEAT_BYTES));
                        remaining  <= remaining - 17'(ddr_rd_len);
                    end
                end
                DATA: begin
                    if (beat_in_burst) begin
                        burst_cnt <= burst_cnt - 5'd1;
                        base_addr <= base_addr + SRAM_AW'(1);
                        // Next request goes out the cycle after the final beat of this burst.
                        if (burst_end && (remaining != 17'd0)) begin
                            ddr_rd_req  <= 1'b1;
                            ddr_rd_addr <= cand_ptr;
                            ddr_rd_len  <= cand_len;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
